load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//   Data-memory access stage of the RV32I core, between execute and writeback.
//   Accepts one load/store per handshake and issues a word-aligned access with
//   byte strobes to data memory. Returns load data byte/half-extracted and sign-
//   or zero-extended (LB/LH/LW/LBU/LHU), plus store completion. Flags misaligned
//   or illegal-funct3 accesses without touching memory.
// PARAMETERS
//   XLEN    32   data width; only 32 is supported
//   ADDR_W  32   byte-address width
// PORTS
//   clk         in   1       core clock, rising edge
//   rst         in   1       asynchronous, active-low reset (0 = reset)
//   req_valid   in   1       execute stage presents an access
//   req_ready   out  1       LSU can accept (IDLE only)
//   req_store   in   1       1 = store, 0 = load
//   req_funct3  in   3       RV32I funct3: LB0 LH1 LW2 LBU4 LHU5 / SB0 SH1 SW2
//   req_addr    in   ADDR_W  byte address (rs1 + imm)
//   req_wdata   in   XLEN    store data (rs2), LSB-aligned
//   mem_valid   out  1       memory request strobe
//   mem_ready   in   1       memory accepts the request this cycle
//   mem_we      out  1       1 = write
//   mem_addr    out  ADDR_W  {req_addr[ADDR_W-1:2],2'b00}
//   mem_wstrb   out  4       byte-lane write enables
//   mem_wdata   out  XLEN    store data shifted to its lanes
//   mem_rvalid  in   1       read data valid
//   mem_rdata   in   XLEN    read word
//   resp_valid  out  1       one-cycle completion pulse
//   resp_data   out  XLEN    extended load result; 0 for stores and errors
//   resp_err    out  1       misaligned or illegal funct3, valid with resp_valid
// BEHAVIOUR
//   Reset (rst=0, async): state=IDLE; req_ready=1; every other output 0.
//   FSM IDLE -> REQ -> (WAIT) -> RESP -> IDLE.
//   IDLE: req_ready=1. On req_valid latch store/funct3/addr/wdata and decode.
//     Error if LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0,
//     load funct3 in {3,6,7}, or store funct3 >=3 -> next RESP, err=1, no mem_valid.
//     Otherwise -> REQ.
//   REQ: mem_valid=1 with mem_we/addr/wstrb/wdata held stable until mem_ready=1.
//     On mem_ready: store -> RESP; load -> WAIT.
//   WAIT: load only. On mem_rvalid capture mem_rdata -> RESP. Unbounded wait.
//     mem_rvalid in any other state is ignored.
//   RESP: resp_valid=1 for exactly one cycle, no backpressure -> IDLE.
//     resp_data/resp_err are registered and change only on RESP entry.
//   Strobes: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111.
//   wdata: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word wdata.
//   Load extract: byte lane = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
//     LB/LH sign-extend, LBU/LHU zero-extend.
//   Latency accept->resp_valid with zero-wait memory: load 3 cycles, store 2, error 1.
//   Throughput: next accept in the cycle after resp_valid (IDLE). At most one
//     outstanding access, no pipelining.
//   Reset mid-operation drops the access. mem_valid deasserts asynchronously and
//   no resp_valid is produced for it. Memory must discard any in-flight read.
// TESTING
//   LB addr 0x1003, rdata 0x80FF0000, zero-wait -> mem_addr 0x1000, wstrb 0,
//     resp_data 0xFFFFFF80 three cycles after accept, err=0.
//   LBU same stimulus -> resp_data 0x00000080. LH addr 0x2002, rdata
//     0x1234ABCD -> 0x00001234. LHU addr 0x2000 -> 0x0000ABCD.
//   SB addr 0x1001 wdata 0xDEADBEAB -> mem_we=1, wstrb 4'b0010, mem_wdata
//     0xABABABAB. SW addr 0x1004 -> wstrb 4'b1111. resp_data 0 in both cases.
//   LW addr 0x1002 -> mem_valid never rises. resp_valid with err=1 one cycle
//     after accept. Same result for LH addr 0x1001 and funct3=3 load.
//   mem_ready low 3 cycles, then rvalid 2 cycles later -> mem_* outputs stable
//     throughout REQ, single resp_valid, req_ready low until IDLE.
//   rst pulsed low during WAIT -> all outputs 0 immediately, no resp_valid.
//     A subsequent LB completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access at a time, word-aligned memory port with
// byte strobes, load extraction/extension, and misaligned/illegal detection.
module load_store_unit #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_data,
    output logic              resp_err
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]        mem_wstrb_q, mem_wstrb_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic [XLEN-1:0]   resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;

    logic              dec_err;
    logic [3:0]        dec_strb;
    logic [XLEN-1:0]   dec_wdata;
    logic [XLEN-1:0]   ld_shift;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   ld_data;

    // Decode of the incoming request, used only in IDLE.
    always_comb begin
        dec_err   = 1'b0;
        dec_strb  = 4'b0000;
        dec_wdata = req_wdata;
        case (req_funct3)
            3'd0: begin
                dec_strb  = 4'b0001 << req_addr[1:0];
                dec_wdata = {4{req_wdata[7:0]}};
            end
            3'd1: begin
                dec_err   = req_addr[0];
                dec_strb  = 4'b0011 << req_addr[1:0];
                dec_wdata = {2{req_wdata[15:0]}};
            end
            3'd2: begin
                dec_err   = (req_addr[1:0] != 2'b00);
                dec_strb  = 4'b1111;
            end
            3'd4:    dec_err = req_store;
            3'd5:    dec_err = req_store | req_addr[0];
            default: dec_err = 1'b1;
        endcase
    end

    always_comb begin
        ld_shift = mem_rdata >> {addr_lo_q, 3'b000};
        ld_half  = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q[1:0])
            2'd0:    ld_data = {{(XLEN-8){ld_shift[7] & ~funct3_q[2]}}, ld_shift[7:0]};
            2'd1:    ld_data = {{(XLEN-16){ld_half[15] & ~funct3_q[2]}}, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_lo_d    = addr_lo_q;
        req_ready_d  = req_ready_q;
        mem_valid_d  = mem_valid_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_wdata_d  = mem_wdata_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: if (req_valid) begin
                store_d     = req_store;
                funct3_d    = req_funct3;
                addr_lo_d   = req_addr[1:0];
                req_ready_d = 1'b0;
                if (dec_err) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                end else begin
                    state_d     = REQ;
                    mem_valid_d = 1'b1;
                    mem_we_d    = req_store;
                    mem_addr_d  = {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wstrb_d = req_store ? dec_strb : 4'b0000;
                    mem_wdata_d = req_store ? dec_wdata : '0;
                end
            end
            REQ: if (mem_ready) begin
                mem_valid_d = 1'b0;
                if (store_q) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_data_d  = '0;
                    resp_err_d   = 1'b0;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: if (mem_rvalid) begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_data_d  = ld_data;
                resp_err_d   = 1'b0;
            end
            RESP: begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= '0;
            addr_lo_q    <= '0;
            req_ready_q  <= 1'b1;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= '0;
            mem_wdata_q  <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_lo_q    <= addr_lo_d;
            req_ready_q  <= req_ready_d;
            mem_valid_q  <= mem_valid_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_wdata_q  <= mem_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign mem_valid  = mem_valid_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: loads, stores, errors, memory stalls,
// and reset in the middle of a load.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        mem_valid, mem_ready, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        resp_valid, resp_err;
    logic [31:0] resp_data;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        chk("req_ready_idle", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        step();
        req_valid = 1'b0;
    endtask

    // Zero-wait load: mem_ready in the REQ cycle, rvalid in the following cycle.
    task automatic run_load(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        present(1'b0, f3, a, 32'h0);
        chk({tag, "_mvalid"}, {31'b0, mem_valid}, 32'd1);
        chk({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        chk({tag, "_wstrb"}, {28'b0, mem_wstrb}, 32'd0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk({tag, "_no_resp_wait"}, {31'b0, resp_valid}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = rd;
        step();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
        chk({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_data"}, resp_data, exp);
        chk({tag, "_err"}, {31'b0, resp_err}, 32'd0);
        step();
        chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] wd, input logic [3:0] strb,
                             input logic [31:0] mwd);
        present(1'b1, f3, a, wd);
        chk({tag, "_mvalid"}, {31'b0, mem_valid}, 32'd1);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd1);
        chk({tag, "_maddr"}, mem_addr, {a[31:2], 2'b00});
        chk({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, strb});
        chk({tag, "_mwdata"}, mem_wdata, mwd);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_data"}, resp_data, 32'h0);
        chk({tag, "_err"}, {31'b0, resp_err}, 32'd0);
        step();
        chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    task automatic run_err(input string tag, input logic st, input logic [2:0] f3,
                           input logic [31:0] a);
        present(st, f3, a, 32'hFFFF_FFFF);
        chk({tag, "_mvalid"}, {31'b0, mem_valid}, 32'd0);
        chk({tag, "_rvalid"}, {31'b0, resp_valid}, 32'd1);
        chk({tag, "_err"}, {31'b0, resp_err}, 32'd1);
        chk({tag, "_data"}, resp_data, 32'h0);
        step();
        chk({tag, "_mvalid2"}, {31'b0, mem_valid}, 32'd0);
        chk({tag, "_pulse"}, {31'b0, resp_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0;
        mem_rdata = 32'h0;
        #12;
        chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        rst = 1'b1;
        step();

        run_load("lb",   3'd0, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
        run_load("lbu",  3'd4, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
        run_load("lb1",  3'd0, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);
        run_load("lh",   3'd1, 32'h0000_2002, 32'h1234_ABCD, 32'h0000_1234);
        run_load("lhn",  3'd1, 32'h0000_2000, 32'h1234_ABCD, 32'hFFFF_ABCD);
        run_load("lhu",  3'd5, 32'h0000_2000, 32'h1234_ABCD, 32'h0000_ABCD);
        run_load("lw",   3'd2, 32'h0000_2004, 32'hCAFE_F00D, 32'hCAFE_F00D);

        run_store("sb",  3'd0, 32'h0000_1001, 32'hDEAD_BEAB, 4'b0010, 32'hABAB_ABAB);
        run_store("sh",  3'd1, 32'h0000_1002, 32'hDEAD_BEEF, 4'b1100, 32'hBEEF_BEEF);
        run_store("sw",  3'd2, 32'h0000_1004, 32'h1234_5678, 4'b1111, 32'h1234_5678);

        run_err("lw_mis",  1'b0, 3'd2, 32'h0000_1002);
        run_err("lh_mis",  1'b0, 3'd1, 32'h0000_1001);
        run_err("ld_f3_3", 1'b0, 3'd3, 32'h0000_1000);
        run_err("sh_mis",  1'b1, 3'd1, 32'h0000_1003);
        run_err("st_f3_4", 1'b1, 3'd4, 32'h0000_1000);

        // Stalled memory: request held three cycles, read data two cycles later.
        present(1'b0, 3'd2, 32'h0000_3000, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_mvalid", {31'b0, mem_valid}, 32'd1);
            chk("stall_maddr", mem_addr, 32'h0000_3000);
            chk("stall_wstrb", {28'b0, mem_wstrb}, 32'd0);
            chk("stall_we", {31'b0, mem_we}, 32'd0);
            chk("stall_ready", {31'b0, req_ready}, 32'd0);
            step();
        end
        chk("stall_mvalid_last", {31'b0, mem_valid}, 32'd1);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("stall_mvalid_drop", {31'b0, mem_valid}, 32'd0);
        step();
        chk("stall_wait_resp", {31'b0, resp_valid}, 32'd0);
        chk("stall_wait_ready", {31'b0, req_ready}, 32'd0);
        mem_rvalid = 1'b1; mem_rdata = 32'h0BAD_CAFE;
        step();
        mem_rvalid = 1'b0;
        chk("stall_resp", {31'b0, resp_valid}, 32'd1);
        chk("stall_data", resp_data, 32'h0BAD_CAFE);
        chk("stall_ready_resp", {31'b0, req_ready}, 32'd0);
        step();
        chk("stall_pulse", {31'b0, resp_valid}, 32'd0);
        chk("stall_ready_idle", {31'b0, req_ready}, 32'd1);
        chk("stall_data_hold", resp_data, 32'h0BAD_CAFE);

        // Reset while waiting for read data drops the access.
        present(1'b0, 3'd0, 32'h0000_1003, 32'h0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        chk("mrst_mvalid", {31'b0, mem_valid}, 32'd0);
        chk("mrst_resp", {31'b0, resp_valid}, 32'd0);
        chk("mrst_data", resp_data, 32'h0);
        chk("mrst_ready", {31'b0, req_ready}, 32'd1);
        step();
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        step();
        mem_rvalid = 1'b0;
        chk("mrst_no_resp", {31'b0, resp_valid}, 32'd0);
        step();
        chk("mrst_no_resp2", {31'b0, resp_valid}, 32'd0);
        run_load("post_lb", 3'd0, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
